sp_ram_req_ctrl: RTL and testbench
==================================

SP_RAM_REQ_CTRL -- requirements
Module: sp_ram_req_ctrl

Interface
REQ-001 Parameter AW, default 10, RAM address width (1024 words).
REQ-002 Parameter DW, default 32, RAM data width.
REQ-003 CLK  in  1  single clock; all state changes on rising edge.
REQ-004 RSTN  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  command valid.
REQ-006 req_ready  out  1  command accepted when req_valid and req_ready are high at a CLK edge.
REQ-007 req_we  in  1  1 = write, 0 = read.
REQ-008 req_addr  in  AW  word address.
REQ-009 req_wdata  in  DW  write data.
REQ-010 rsp_valid  out  1  read data valid.
REQ-011 rsp_ready  in  1  consumer accepts read data.
REQ-012 rsp_rdata  out  DW  read data.
REQ-013 clr_start  in  1  pulse; request zero-fill of the whole RAM.
REQ-014 clr_busy  out  1  zero-fill in progress.
REQ-015 clr_done  out  1  one-cycle pulse after the last zero-fill write.
REQ-016 ram_cen  out  1  RAM port enable, active high.
REQ-017 ram_wen  out  1  RAM write enable, active high.
REQ-018 ram_a  out  AW  RAM address.
REQ-019 ram_d  out  DW  RAM write data.
REQ-020 ram_q  in  DW  RAM read data, valid one cycle after a read access (write-first RAM).

Function
REQ-021 FSM states IDLE and CLEAR; IDLE serves commands, CLEAR performs the zero-fill.
REQ-022 In IDLE, accepted command drives RAM port combinationally in the same cycle: ram_cen=1, ram_wen=req_we, ram_a=req_addr, ram_d=req_wdata.
REQ-023 No accepted command and not CLEAR: ram_cen=0, ram_wen=0.
REQ-024 Writes produce no response; reads produce exactly one response, in acceptance order.
REQ-025 Read latency: accepted at edge N, ram_q captured at edge N+1, rsp_valid high from cycle after N+1 at earliest.
REQ-026 Response buffer: 2-entry FIFO; credit count = buffered entries + reads in flight, range 0..2.
REQ-027 req_ready = (state==IDLE) and (credit count < 2); req_ready SHALL NOT depend on req_we, req_valid or rsp_ready.
REQ-028 Capture and pop in same cycle at count 2 SHALL leave count 2 with no data loss.
REQ-029 rsp_rdata/rsp_valid stable while rsp_valid=1 and rsp_ready=0.
REQ-030 clr_start in IDLE: enter CLEAR next cycle; command offered in the clr_start cycle is still accepted if req_ready=1.
REQ-031 clr_start ignored while in CLEAR.
REQ-032 CLEAR: one write per cycle, ram_cen=1, ram_wen=1, ram_d=0, ram_a from address counter 0 up to 2^AW-1.
REQ-033 After write to 2^AW-1: clr_done=1 for one cycle, counter wraps to 0, return to IDLE; CLEAR lasts exactly 2^AW cycles.
REQ-034 clr_busy=1 exactly while state==CLEAR; req_ready=0 during CLEAR.
REQ-035 Read in flight on CLEAR entry SHALL still be captured; response side drains normally during CLEAR.

Reset
REQ-036 RSTN low: state IDLE, credit count 0, FIFO empty, address counter 0.
REQ-037 Outputs during/after reset: req_ready=1, rsp_valid=0, rsp_rdata=0, clr_busy=0, clr_done=0, ram_cen=0, ram_wen=0, ram_a=0, ram_d=0.
REQ-038 Reset mid-CLEAR or with reads in flight SHALL discard them; no response after reset release.

Structure
REQ-039 Shared package holds AW/DW defaults and the state enum {IDLE, CLEAR}.
REQ-040 Response buffer SHALL be sub-module sp_ram_rsp_fifo (2-entry, valid/ready, async active-low reset).
REQ-041 SP32B1024 instantiated only in the bench/top, not inside this block.

Verification
REQ-042 Write 0xDEADBEEF @0x3FF, then read 0x3FF, rsp_ready=1 -> rsp_rdata=0xDEADBEEF two cycles after read acceptance.
REQ-043 rsp_ready=0, three back-to-back reads @1,@2,@3 -> first two accepted, req_ready=0 after second; release rsp_ready -> responses data@1, data@2, then read @3 accepted, in order.
REQ-044 Fill 0x0..0x3FF with address values, pulse clr_start -> clr_busy 1024 cycles, clr_done single pulse, every subsequent read returns 0x0.
REQ-045 Read @5 accepted in clr_start cycle -> response data@5 delivered during CLEAR.
REQ-046 Assert RSTN low at clear address 0x200 with one read in flight -> all outputs at reset values, rsp_valid stays 0 after release.
REQ-047 Buffer full, rsp_ready=1 and capture in same cycle -> count stays 2, no response dropped or duplicated.

Source files
------------

// File: rtl/sp_ram_req_ctrl_pkg.sv
// Shared definitions for the single-port RAM request controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default address/data widths and the controller state encoding.
package sp_ram_req_ctrl_pkg;

  localparam int AW_DEF = 10;
  localparam int DW_DEF = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/sp_ram_rsp_fifo.sv
// Two-entry read-response buffer between the RAM output and the consumer.
// Latency: one cycle from push to out_vld; out_dat is the registered head entry.
// Backpressure: holds head stable while out_rdy is low; the producer must never
//               push into a full buffer unless the head is popped in the same cycle.
// Ports: CLK/RSTN clock and async active-low reset; in_vld/in_dat push side;
//        out_vld/out_rdy/out_dat pop side; count = entries currently held (0..2).
module sp_ram_rsp_fifo
  import sp_ram_req_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          in_vld,
  input  logic [DW-1:0] in_dat,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_dat,
  output logic [1:0]    count
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    cnt;
  logic          push;
  logic          pop;

  assign push    = in_vld;
  assign pop     = out_vld & out_rdy;
  assign out_vld = (cnt != 2'd0);
  // Head is shown even when empty so the data output reads zero out of reset.
  assign out_dat = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      // When full with a simultaneous pop, wr_ptr equals rd_ptr: the slot being
      // overwritten is the one leaving this cycle, so nothing is lost.
      if (push) begin
        mem[wr_ptr] <= in_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (push && !pop) begin
        cnt <= cnt + 2'd1;
      end else if (pop && !push) begin
        cnt <= cnt - 2'd1;
      end
    end
  end

endmodule

// File: rtl/sp_ram_req_ctrl.sv
// Command front-end for a single-port RAM with ordered read responses and zero-fill.
// Latency: command drives the RAM in its acceptance cycle; read data valid two edges later.
// Backpressure: req_ready drops while zero-filling or when two reads are outstanding;
//               responses wait in a 2-entry buffer until rsp_ready.
// Ports: CLK/RSTN; req_* command channel; rsp_* read-response channel;
//        clr_start/clr_busy/clr_done zero-fill control; ram_* RAM port (ram_q returns data).
module sp_ram_req_ctrl
  import sp_ram_req_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          ram_cen,
  output logic          ram_wen,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_d,
  input  logic [DW-1:0] ram_q
);

  state_t        state;
  state_t        state_nxt;
  logic          rd_inflight;
  logic [AW-1:0] clr_addr;
  logic          clr_done_q;
  logic [1:0]    fifo_cnt;
  logic [1:0]    credit;
  logic          accept;
  logic          clr_last;

  // Every outstanding read owns a buffer slot from acceptance until it is popped,
  // so the buffer can never overflow regardless of rsp_ready.
  assign credit    = fifo_cnt + {1'b0, rd_inflight};
  assign req_ready = (state == IDLE) && (credit < 2'd2);
  assign accept    = req_valid & req_ready;
  assign clr_last  = (state == CLEAR) && (clr_addr == '1);
  assign clr_busy  = (state == CLEAR);
  assign clr_done  = clr_done_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state       <= IDLE;
      rd_inflight <= 1'b0;
      clr_addr    <= '0;
      clr_done_q  <= 1'b0;
    end else begin
      state       <= state_nxt;
      // RAM data for this read appears on ram_q next cycle and is pushed then,
      // independent of state so a read issued alongside clr_start still lands.
      rd_inflight <= accept & ~req_we;
      clr_done_q  <= clr_last;
      if (state == CLEAR) begin
        clr_addr <= clr_addr + AW'(1);  // wraps back to zero after the top word
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ram_cen   = 1'b0;
    ram_wen   = 1'b0;
    ram_a     = '0;
    ram_d     = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          ram_cen = 1'b1;
          ram_wen = req_we;
          ram_a   = req_addr;
          ram_d   = req_wdata;
        end
        if (clr_start) begin
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        ram_cen = 1'b1;
        ram_wen = 1'b1;
        ram_a   = clr_addr;
        if (clr_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  sp_ram_rsp_fifo #(
    .DW (DW)
  ) u_rsp_fifo (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .in_vld  (rd_inflight),
    .in_dat  (ram_q),
    .out_vld (rsp_valid),
    .out_rdy (rsp_ready),
    .out_dat (rsp_rdata),
    .count   (fifo_cnt)
  );

endmodule

// File: tb/tb_sp_ram_req_ctrl.sv
// Self-checking bench for sp_ram_req_ctrl with a behavioural RAM attached.
// Latency: n/a.
// Backpressure: exercised through rsp_ready patterns.
module tb_sp_ram_req_ctrl;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          clr_start;
  logic          clr_busy;
  logic          clr_done;
  logic          ram_cen;
  logic          ram_wen;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_d;
  logic [DW-1:0] ram_q;

  always #5 CLK = ~CLK;

  sp_ram_req_ctrl #(.AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_a(ram_a), .ram_d(ram_d),
    .ram_q(ram_q)
  );

  // Behavioural write-first single-port RAM.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge CLK) begin
    if (ram_cen) begin
      if (ram_wen) begin
        ram[ram_a] <= ram_d;
        ram_q      <= ram_d;
      end else begin
        ram_q <= ram[ram_a];
      end
    end
  end

  // Reference model: memory contents, queue of pending read results with the
  // edge number at which each read was accepted, and zero-fill progress.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] rq_dat [$];
  int            rq_t [$];
  bit            clearing;
  int            clr_idx;
  bit            done_pend;
  int            cyc;
  int            total;
  int            bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare every output with the model, take the edge.
  task automatic step(input bit v, input bit we, input int addr, input logic [DW-1:0] wd,
                      input bit rr, input bit cs, output bit acc);
    bit            exp_rdy;
    bit            exp_rv;
    logic          exp_cen;
    logic          exp_wen;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    req_valid = v;
    req_we    = we;
    req_addr  = AW'(addr);
    req_wdata = wd;
    rsp_ready = rr;
    clr_start = cs;
    #2;
    exp_rdy = !clearing && (rq_dat.size() < 2);
    acc     = v && exp_rdy;
    exp_rv  = (rq_dat.size() > 0) && (rq_t[0] + 1 <= cyc);
    exp_cen = 1'b0; exp_wen = 1'b0; exp_a = '0; exp_d = '0;
    if (clearing) begin
      exp_cen = 1'b1; exp_wen = 1'b1; exp_a = AW'(clr_idx);
    end else if (acc) begin
      exp_cen = 1'b1; exp_wen = we; exp_a = AW'(addr); exp_d = wd;
    end
    chk("req_ready", req_ready, exp_rdy);
    chk("rsp_valid", rsp_valid, exp_rv);
    if (exp_rv) chk("rsp_rdata", rsp_rdata, rq_dat[0]);
    chk("ram_cen", ram_cen, exp_cen);
    chk("ram_wen", ram_wen, exp_wen);
    chk("ram_a", ram_a, exp_a);
    chk("ram_d", ram_d, exp_d);
    chk("clr_busy", clr_busy, clearing);
    chk("clr_done", clr_done, done_pend);
    @(posedge CLK);
    cyc++;
    if (exp_rv && rr) begin
      void'(rq_dat.pop_front());
      void'(rq_t.pop_front());
    end
    if (acc) begin
      if (we) ref_mem[addr] = wd;
      else begin
        rq_dat.push_back(ref_mem[addr]);
        rq_t.push_back(cyc);
      end
    end
    done_pend = 1'b0;
    if (clearing) begin
      ref_mem[clr_idx] = '0;
      if (clr_idx == DEPTH - 1) begin
        clearing  = 1'b0;
        clr_idx   = 0;
        done_pend = 1'b1;
      end else begin
        clr_idx++;
      end
    end else if (cs) begin
      clearing = 1'b1;
    end
    #1;
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; clr_start = 1'b0;
    #2;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, '0);
    chk("rst_clr_busy", clr_busy, 1'b0);
    chk("rst_clr_done", clr_done, 1'b0);
    chk("rst_ram_cen", ram_cen, 1'b0);
    chk("rst_ram_wen", ram_wen, 1'b0);
    chk("rst_ram_a", ram_a, '0);
    chk("rst_ram_d", ram_d, '0);
    @(posedge CLK);
    #1;
    cyc++;
    RSTN = 1'b1;
    rq_dat.delete();
    rq_t.delete();
    clearing  = 1'b0;
    clr_idx   = 0;
    done_pend = 1'b0;
  endtask

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl [12];

  initial begin
    bit a;
    int busy_n;
    int done_n;
    int seen5;
    int nz;
    int addr;

    tbl[0]  = '{1'b1, 10'h3FF, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b0, 10'h3FF, 32'h0,        32'hDEADBEEF};
    tbl[2]  = '{1'b1, 10'h000, 32'h12345678, 32'h0};
    tbl[3]  = '{1'b0, 10'h000, 32'h0,        32'h12345678};
    tbl[4]  = '{1'b1, 10'h155, 32'hA5A5A5A5, 32'h0};
    tbl[5]  = '{1'b1, 10'h2AA, 32'h5A5A5A5A, 32'h0};
    tbl[6]  = '{1'b0, 10'h155, 32'h0,        32'hA5A5A5A5};
    tbl[7]  = '{1'b0, 10'h2AA, 32'h0,        32'h5A5A5A5A};
    tbl[8]  = '{1'b1, 10'h3FF, 32'h00000001, 32'h0};
    tbl[9]  = '{1'b0, 10'h3FF, 32'h0,        32'h00000001};
    tbl[10] = '{1'b1, 10'h001, 32'hFFFFFFFF, 32'h0};
    tbl[11] = '{1'b0, 10'h001, 32'h0,        32'hFFFFFFFF};

    total = 0; bad = 0; cyc = 0;
    clearing = 1'b0; clr_idx = 0; done_pend = 1'b0;
    do_reset();

    // Preload the low words so every later read hits known data.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, i, 32'h1000_0000 + i, 1'b1, 1'b0, a);

    // Table vectors: each read must return its expected word two edges after acceptance.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, tbl[i].we, int'(tbl[i].addr), tbl[i].wdata, 1'b1, 1'b0, a);
      if (!tbl[i].we) begin
        step(1'b0, 1'b0, 0, '0, 1'b0, 1'b0, a);
        chk("tbl_rsp_valid", rsp_valid, 1'b1);
        chk("tbl_rsp_rdata", rsp_rdata, tbl[i].exp);
        step(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, a);
      end
    end

    // Consumer stalled: two reads fill the credit, the third waits.
    step(1'b1, 1'b1, 1, 32'h0000_00A1, 1'b1, 1'b0, a);
    step(1'b1, 1'b1, 2, 32'h0000_00A2, 1'b1, 1'b0, a);
    step(1'b1, 1'b1, 3, 32'h0000_00A3, 1'b1, 1'b0, a);
    step(1'b1, 1'b0, 1, '0, 1'b0, 1'b0, a);
    step(1'b1, 1'b0, 2, '0, 1'b0, 1'b0, a);
    chk("bp_ready_low", req_ready, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 3, '0, 1'b0, 1'b0, a);
      chk("bp_hold_valid", rsp_valid, 1'b1);
      chk("bp_hold_data", rsp_rdata, 32'h0000_00A1);
    end
    step(1'b1, 1'b0, 3, '0, 1'b1, 1'b0, a);
    chk("bp_second", rsp_rdata, 32'h0000_00A2);
    step(1'b1, 1'b0, 3, '0, 1'b1, 1'b0, a);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, a);

    // Full credit: pop of the head coincides with capture of the second read.
    step(1'b1, 1'b1, 6, 32'h0000_00B6, 1'b1, 1'b0, a);
    step(1'b1, 1'b1, 7, 32'h0000_00B7, 1'b1, 1'b0, a);
    step(1'b1, 1'b0, 6, '0, 1'b0, 1'b0, a);
    step(1'b1, 1'b0, 7, '0, 1'b0, 1'b0, a);
    step(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, a);
    chk("full_next_valid", rsp_valid, 1'b1);
    chk("full_next_data", rsp_rdata, 32'h0000_00B7);
    step(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, a);
    chk("full_no_dup", rsp_valid, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
           $urandom, ($urandom_range(0, 3) != 0), 1'b0, a);
    end
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, a);

    // Fill every word with its own address, then zero-fill with a read issued alongside.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, i, DW'(i), 1'b1, 1'b0, a);
    busy_n = 0; done_n = 0; seen5 = 0;
    step(1'b1, 1'b0, 5, '0, 1'b1, 1'b1, a);
    if (clr_busy) busy_n++;
    for (int k = 0; k < 1030; k++) begin
      step(1'b0, 1'b0, 0, '0, 1'b1, (k == 3), a);
      if (clr_busy) busy_n++;
      if (clr_done) done_n++;
      if (clr_busy && rsp_valid && rsp_rdata == 32'd5) seen5++;
    end
    chk("clr_busy_cycles", busy_n, DEPTH);
    chk("clr_done_pulses", done_n, 1);
    chk("rsp_during_clear", seen5, 1);

    // Every word must now read back as zero.
    addr = 0; nz = 0;
    for (int k = 0; k < 4000 && addr < DEPTH; k++) begin
      step(1'b1, 1'b0, addr, '0, 1'b1, 1'b0, a);
      if (rsp_valid && rsp_rdata != '0) nz++;
      if (a) addr++;
    end
    chk("rd_all_done", addr, DEPTH);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, a);
      if (rsp_valid && rsp_rdata != '0) nz++;
    end
    chk("clr_all_zero", nz, 0);

    // Reset in the middle of a zero-fill with a read result still pending.
    step(1'b1, 1'b1, 10'h1FF, 32'h0000_01FF, 1'b1, 1'b0, a);
    step(1'b1, 1'b1, 10'h200, 32'h0000_0200, 1'b1, 1'b0, a);
    step(1'b1, 1'b0, 5, '0, 1'b0, 1'b1, a);
    for (int k = 0; k < 2000 && !(clearing && clr_idx == 10'h200); k++)
      step(1'b0, 1'b0, 0, '0, 1'b0, 1'b0, a);
    chk("mid_clear_addr", ram_a, 10'h200);
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, a);
      chk("post_rst_no_rsp", rsp_valid, 1'b0);
    end
    step(1'b1, 1'b0, 10'h1FF, '0, 1'b0, 1'b0, a);
    step(1'b0, 1'b0, 0, '0, 1'b0, 1'b0, a);
    chk("post_rst_1ff", rsp_rdata, 32'h0);
    step(1'b1, 1'b0, 10'h200, '0, 1'b1, 1'b0, a);
    step(1'b0, 1'b0, 0, '0, 1'b0, 1'b0, a);
    chk("post_rst_200", rsp_rdata, 32'h0000_0200);
    step(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, a);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
